// File: rtl/plc_input_scan.sv
// Input-image reader: synchronizes and debounces board inputs, normalizes key polarity,
// and hands the scan engine a frozen image plus edge flags over a level handshake.
module plc_input_scan #(
    parameter int              N_IN            = 23,
    parameter int              DEBOUNCE_TICKS  = 10,
    parameter logic [N_IN-1:0] ACTIVE_LOW_MASK = 23'h780000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_IN-1:0] raw_in,
    input  logic            scan_req,
    output logic            scan_ack,
    output logic [N_IN-1:0] img,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall
);

    localparam int CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((DEBOUNCE_TICKS > 0) ? DEBOUNCE_TICKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    logic [N_IN-1:0] sync1_reg, sync2_reg;
    logic [N_IN-1:0] s;
    logic [N_IN-1:0] stable_reg;
    state_t          state_reg, state_next;

    // Reset to the idle-key pattern so released keys do not look like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= ACTIVE_LOW_MASK;
            sync2_reg <= ACTIVE_LOW_MASK;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg ^ ACTIVE_LOW_MASK;

    genvar gi;
    generate
        if (DEBOUNCE_TICKS == 0) begin : g_nodeb
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) stable_reg <= '0;
                else      stable_reg <= s;
            end
        end else begin : g_deb
            for (gi = 0; gi < N_IN; gi++) begin : g_bit
                logic [CW-1:0] cnt_reg;
                // Counter only ever reaches LAST before clearing, so it cannot wrap.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        cnt_reg        <= '0;
                        stable_reg[gi] <= 1'b0;
                    end else if (s[gi] == stable_reg[gi]) begin
                        cnt_reg <= '0;
                    end else if (tick) begin
                        if (cnt_reg >= LAST) begin
                            stable_reg[gi] <= s[gi];
                            cnt_reg        <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        scan_ack   = 1'b0;
        case (state_reg)
            IDLE:    if (scan_req) state_next = CAPTURE;
            CAPTURE: state_next = HOLD;
            HOLD: begin
                scan_ack = 1'b1;
                if (!scan_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Edges are taken against the previous capture, not against every stable change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            img  <= '0;
            rise <= '0;
            fall <= '0;
        end else if (state_reg == CAPTURE) begin
            img  <= stable_reg;
            rise <= stable_reg & ~img;
            fall <= ~stable_reg & img;
        end
    end

endmodule

// File: tb/tb_plc_input_scan.sv
// Directed bench for plc_input_scan: vector table of scans plus multi-cycle corner cases.
module tb_plc_input_scan;

    logic        clk = 0;
    logic        rst;
    logic        tick;
    logic [22:0] raw_in, raw0;
    logic        scan_req, scan_req0;
    logic        scan_ack, scan_ack0;
    logic [22:0] img, rise, fall, img0, rise0, fall0;
    logic        tick0;

    int n_cmp  = 0;
    int n_fail = 0;

    plc_input_scan dut (
        .clk(clk), .rst(rst), .tick(tick), .raw_in(raw_in), .scan_req(scan_req),
        .scan_ack(scan_ack), .img(img), .rise(rise), .fall(fall)
    );

    plc_input_scan #(.DEBOUNCE_TICKS(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick0), .raw_in(raw0), .scan_req(scan_req0),
        .scan_ack(scan_ack0), .img(img0), .rise(rise0), .fall(fall0)
    );

    always #5 clk = ~clk;

    initial begin
        tick  = 0;
        tick0 = 0;
        forever begin
            repeat (4) @(negedge clk);
            tick = 1;
            @(negedge clk);
            tick = 0;
        end
    end

    typedef struct {
        logic [22:0] raw;
        logic [22:0] e_img;
        logic [22:0] e_rise;
        logic [22:0] e_fall;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        @(negedge clk);
    endtask

    // Raise scan_req at a negedge and check the two-edge ack latency and captured data.
    task automatic scan(input string name, input logic [22:0] e_img, input logic [22:0] e_rise,
                        input logic [22:0] e_fall, input bit release_req);
        scan_req = 1;
        @(negedge clk);
        chk({name, " ack_lat1"}, {22'd0, scan_ack}, 23'd0);
        @(negedge clk);
        chk({name, " ack"},  {22'd0, scan_ack}, 23'd1);
        chk({name, " img"},  img,  e_img);
        chk({name, " rise"}, rise, e_rise);
        chk({name, " fall"}, fall, e_fall);
        $display("scan %s: img=%h rise=%h fall=%h", name, img, rise, fall);
        if (release_req) begin
            scan_req = 0;
            @(negedge clk);
            chk({name, " ack_drop"}, {22'd0, scan_ack}, 23'd0);
        end
    endtask

    initial begin
        vecs[0] = '{23'h780000, 23'h000000, 23'h000000, 23'h000000};
        vecs[1] = '{23'h700000, 23'h080000, 23'h080000, 23'h000000};
        vecs[2] = '{23'h700000, 23'h080000, 23'h000000, 23'h000000};
        vecs[3] = '{23'h780000, 23'h000000, 23'h000000, 23'h080000};
        vecs[4] = '{23'h780005, 23'h000005, 23'h000005, 23'h000000};
        vecs[5] = '{23'h000000, 23'h780000, 23'h780000, 23'h000005};
        vecs[6] = '{23'h78000A, 23'h00000A, 23'h00000A, 23'h780000};
        vecs[7] = '{23'h780000, 23'h000000, 23'h000000, 23'h00000A};

        rst       = 0;
        raw_in    = 23'h780000;
        raw0      = 23'h780000;
        scan_req  = 0;
        scan_req0 = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset ack", {22'd0, scan_ack}, 23'd0);
            chk("reset img", img, 23'd0);
        end

        for (int i = 0; i < 8; i++) begin
            raw_in = vecs[i].raw;
            wait_ticks(12);
            scan($sformatf("vec%0d", i), vecs[i].e_img, vecs[i].e_rise, vecs[i].e_fall, 1);
        end

        // SW[3] bounce: every interval is shorter than the debounce window.
        wait_ticks(1);
        for (int i = 0; i < 10; i++) begin
            raw_in[3] = (i % 2 == 0);
            for (int t = 0; t < 3; t++) begin
                wait_ticks(1);
                chk("bounce stable3", {22'd0, dut.stable_reg[3]}, 23'd0);
            end
        end
        raw_in[3] = 1;
        wait_ticks(9);
        chk("settle 9 ticks", {22'd0, dut.stable_reg[3]}, 23'd0);
        wait_ticks(1);
        chk("settle 10 ticks", {22'd0, dut.stable_reg[3]}, 23'd1);
        scan("bounce", 23'h000008, 23'h000008, 23'h000000, 1);

        // Hold scan_req high; image must stay frozen through a debounced change.
        scan("hold", 23'h000008, 23'h000000, 23'h000000, 0);
        raw_in = 23'h780009;
        wait_ticks(12);
        chk("frozen ack",  {22'd0, scan_ack}, 23'd1);
        chk("frozen img",  img,  23'h000008);
        chk("frozen rise", rise, 23'h000000);
        chk("frozen fall", fall, 23'h000000);
        scan_req = 0;
        @(negedge clk);
        chk("hold drop ack", {22'd0, scan_ack}, 23'd0);
        scan("rereq", 23'h000009, 23'h000001, 23'h000000, 1);

        // Reset mid-HOLD with img = 5.
        raw_in = 23'h780005;
        wait_ticks(12);
        scan("pre_rst", 23'h000005, 23'h000004, 23'h000008, 0);
        rst      = 0;
        scan_req = 0;
        #1;
        chk("rst ack",  {22'd0, scan_ack}, 23'd0);
        chk("rst img",  img,  23'd0);
        chk("rst rise", rise, 23'd0);
        chk("rst fall", fall, 23'd0);
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("post_rst idle ack", {22'd0, scan_ack}, 23'd0);
        wait_ticks(12);
        scan("post_rst", 23'h000005, 23'h000005, 23'h000000, 1);

        // No-debounce build: no tick reaches dut0 at all.
        raw0 = 23'h780002;
        repeat (4) @(negedge clk);
        chk("nodeb stable", dut0.stable_reg, 23'h000002);
        scan_req0 = 1;
        repeat (2) @(negedge clk);
        chk("nodeb ack",  {22'd0, scan_ack0}, 23'd1);
        chk("nodeb img",  img0,  23'h000002);
        chk("nodeb rise", rise0, 23'h000002);
        chk("nodeb fall", fall0, 23'h000000);
        $display("scan nodeb: img=%h rise=%h fall=%h", img0, rise0, fall0);
        scan_req0 = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
